// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, encodings and compare helpers for the hazard controller
package hazard_pkg;

    localparam int TNEW_W = 2;
    localparam int TUSE_W = 2;
    localparam int REG_W  = 5;

    typedef logic [REG_W-1:0]  reg_addr_t;
    typedef logic [TNEW_W-1:0] tnew_t;
    typedef logic [TUSE_W-1:0] tuse_t;

    // Tuse value meaning the operand is not read at all
    localparam tuse_t TUSE_NONE = 2'd3;

    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_M   = 2'd1,
        FWD_E   = 2'd2
    } fwd_sel_e;

    // What the controller remembers about the instruction held in a stage
    typedef struct packed {
        reg_addr_t wa;
        tnew_t     tnew;
        logic      md_start;
        logic      md_div;
    } stage_t;

    // Tnew counts down as an instruction advances, but never below zero
    function automatic tnew_t sat_dec(input tnew_t t);
        return (t == '0) ? '0 : t - tnew_t'(1);
    endfunction

    // Read-after-write hazard for one D-stage operand. With forwarding, only a
    // producer that is still too young (Tnew > Tuse) stalls. Without it, any
    // in-flight writer of a read register stalls; W is covered by the GRF
    // writing before it is read.
    function automatic logic reg_hazard(
        input reg_addr_t r,
        input tuse_t     tuse,
        input reg_addr_t e_wa,
        input tnew_t     e_tnew,
        input reg_addr_t m_wa,
        input tnew_t     m_tnew,
        input logic      fwd_en
    );
        logic e_hit;
        logic m_hit;
        e_hit = (r == e_wa);
        m_hit = (r == m_wa);
        if (r == '0)
            return 1'b0;
        if (fwd_en)
            return (e_hit && (e_tnew > tuse)) || (m_hit && (m_tnew > tuse));
        return (tuse != TUSE_NONE) && (e_hit || m_hit);
    endfunction

    // Youngest ready producer wins: E before M, otherwise the register file
    function automatic fwd_sel_e fwd_pick(
        input reg_addr_t r,
        input reg_addr_t e_wa,
        input tnew_t     e_tnew,
        input reg_addr_t m_wa,
        input tnew_t     m_tnew
    );
        if (r != '0 && r == e_wa && e_tnew == '0)
            return FWD_E;
        if (r != '0 && r == m_wa && m_tnew == '0)
            return FWD_M;
        return FWD_GRF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - D-stage decode info in, stall/forward controls out
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic      d_valid;
    reg_addr_t d_rs;
    reg_addr_t d_rt;
    tuse_t     d_tuse_rs;
    tuse_t     d_tuse_rt;
    reg_addr_t d_wa;
    tnew_t     d_tnew;
    logic      d_md_start;
    logic      d_md_div;
    logic      d_md_use;

    logic       stall;
    logic       flush_e;
    logic [1:0] fwd_rs_sel;
    logic [1:0] fwd_rt_sel;
    logic       md_busy;

    modport master (
        output d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew,
               d_md_start, d_md_div, d_md_use,
        input  stall, flush_e, fwd_rs_sel, fwd_rt_sel, md_busy
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_wa, d_tnew,
               d_md_start, d_md_div, d_md_use,
        output stall, flush_e, fwd_rs_sel, fwd_rt_sel, md_busy
    );

endinterface

// File: rtl/hazard_ctrl_md_busy_timer.sv
// rtl/hazard_ctrl_md_busy_timer.sv - mult/div unit busy window counter
module md_busy_timer #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic load_div,
    output logic md_busy
);

    logic [CNT_W-1:0] cnt;

    // Reload on issue from E, otherwise count the busy window down to idle
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign md_busy = (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller (HAZARD_FWD_EN enables Tnew/Tuse forwarding)
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hif
);

`ifdef HAZARD_FWD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    stage_t    e_q;
    stage_t    e_d;
    reg_addr_t m_wa;
    tnew_t     m_tnew;

    logic     md_busy;
    logic     rs_haz;
    logic     rt_haz;
    logic     md_stall;
    logic     stall;
    fwd_sel_e rs_sel;
    fwd_sel_e rt_sel;

    md_busy_timer #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (e_q.md_start),
        .load_div (e_q.md_div),
        .md_busy  (md_busy)
    );

    // Operand hazards, MDU occupancy and forward selects for the D-stage instruction
    always_comb begin
        rs_haz   = reg_hazard(hif.d_rs, hif.d_tuse_rs, e_q.wa, e_q.tnew, m_wa, m_tnew, FWD_EN);
        rt_haz   = reg_hazard(hif.d_rt, hif.d_tuse_rt, e_q.wa, e_q.tnew, m_wa, m_tnew, FWD_EN);
        md_stall = hif.d_valid && hif.d_md_use && (md_busy || e_q.md_start);
        stall    = hif.d_valid && (rs_haz || rt_haz || md_stall);
        rs_sel   = FWD_GRF;
        rt_sel   = FWD_GRF;
        if (FWD_EN) begin
            rs_sel = fwd_pick(hif.d_rs, e_q.wa, e_q.tnew, m_wa, m_tnew);
            rt_sel = fwd_pick(hif.d_rt, e_q.wa, e_q.tnew, m_wa, m_tnew);
        end
    end

    assign hif.stall      = stall;
    assign hif.flush_e    = stall;
    assign hif.fwd_rs_sel = rs_sel;
    assign hif.fwd_rt_sel = rt_sel;
    assign hif.md_busy    = md_busy;

    // Next E contents: the D instruction, or a bubble when stalled or D is empty
    always_comb begin
        e_d = '0;
        if (hif.d_valid && !stall) begin
            e_d.wa       = hif.d_wa;
            e_d.tnew     = hif.d_tnew;
            e_d.md_start = hif.d_md_start;
            e_d.md_div   = hif.d_md_div;
        end
    end

    // Advance the E/M tracking registers, ageing Tnew on the way into M
    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q    <= '0;
            m_wa   <= '0;
            m_tnew <= '0;
        end else begin
            e_q    <= e_d;
            m_wa   <= e_q.wa;
            m_tnew <= sat_dec(e_q.tnew);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed checks for hazard_ctrl
module tb_hazard_ctrl;

`ifdef HAZARD_FWD_EN
    localparam int FWD = 1;
`else
    localparam int FWD = 0;
`endif

    logic clk;
    logic reset;
    int   n_total;
    int   n_pass;

    hazard_ctrl_if hif ();

    hazard_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hif   (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input int rs, input int rt, input int tu_rs,
                         input int tu_rt, input int wa, input int tnew,
                         input logic mds, input logic mdd, input logic mdu);
        hif.d_valid    = v;
        hif.d_rs       = 5'(rs);
        hif.d_rt       = 5'(rt);
        hif.d_tuse_rs  = 2'(tu_rs);
        hif.d_tuse_rt  = 2'(tu_rt);
        hif.d_wa       = 5'(wa);
        hif.d_tnew     = 2'(tnew);
        hif.d_md_start = mds;
        hif.d_md_div   = mdd;
        hif.d_md_use   = mdu;
    endtask

    task automatic nop();
        drive(1'b0, 0, 0, 3, 3, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            nop();
        end
    endtask

    task automatic chk_out(input string tag, input int e_stall, input int e_rs, input int e_rt);
        check({tag, ".stall"},   int'(hif.stall),      e_stall);
        check({tag, ".flush_e"}, int'(hif.flush_e),    e_stall);
        check({tag, ".fwd_rs"},  int'(hif.fwd_rs_sel), e_rs);
        check({tag, ".fwd_rt"},  int'(hif.fwd_rt_sel), e_rt);
    endtask

    // Issue an MDU op, follow it with mflo and measure the stall and busy windows
    task automatic run_md(input string tag, input logic is_div, input int exp_stall, input int exp_busy);
        int stall_cnt;
        int busy_cnt;
        stall_cnt = 0;
        busy_cnt  = 0;
        @(negedge clk);
        drive(1'b1, 0, 0, 3, 3, 0, 0, 1'b1, is_div, 1'b1);
        #1;
        check({tag, ".issue_stall"}, int'(hif.stall), 0);
        check({tag, ".issue_busy"},  int'(hif.md_busy), 0);
        @(negedge clk);
        drive(1'b1, 0, 0, 3, 3, 8, 1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 30; i++) begin
            #1;
            if (!hif.stall)
                break;
            stall_cnt++;
            if (hif.md_busy)
                busy_cnt++;
            @(negedge clk);
        end
        check({tag, ".stall_cycles"}, stall_cnt, exp_stall);
        check({tag, ".busy_cycles"},  busy_cnt,  exp_busy);
        check({tag, ".busy_after"},   int'(hif.md_busy), 0);
        idle(2);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        reset   = 1'b0;
        nop();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk_out("reset", 0, 0, 0);
        check("reset.md_busy", int'(hif.md_busy), 0);
        reset = 1'b1;

        // lw $1 (Tnew 2) then add reading $1 with Tuse 1
        @(negedge clk);
        drive(1'b1, 0, 0, 3, 3, 1, 2, 1'b0, 1'b0, 1'b0);
        #1 chk_out("t1_lw", 0, 0, 0);
        @(negedge clk);
        drive(1'b1, 1, 0, 1, 3, 4, 1, 1'b0, 1'b0, 1'b0);
        #1 chk_out("t1_add_e", 1, 0, 0);
        @(negedge clk);
        #1 chk_out("t1_add_m", (FWD != 0) ? 0 : 1, 0, 0);
        idle(2);

        // addu $2 (Tnew 1) then beq reading $2 with Tuse 0
        @(negedge clk);
        drive(1'b1, 0, 0, 3, 3, 2, 1, 1'b0, 1'b0, 1'b0);
        #1 chk_out("t2_addu", 0, 0, 0);
        @(negedge clk);
        drive(1'b0, 2, 0, 0, 3, 0, 0, 1'b0, 1'b0, 1'b0);
        #1 check("t2_bubble.stall", int'(hif.stall), 0);
        hif.d_valid = 1'b1;
        #1 chk_out("t2_beq_e", 1, 0, 0);
        @(negedge clk);
        #1 chk_out("t2_beq_m", (FWD != 0) ? 0 : 1, (FWD != 0) ? 1 : 0, 0);
        idle(2);

        // ori $3 (Tnew 0) then an instruction reading $3 as rt with Tuse 1
        @(negedge clk);
        drive(1'b1, 0, 0, 3, 3, 3, 0, 1'b0, 1'b0, 1'b0);
        #1 chk_out("t3_ori", 0, 0, 0);
        @(negedge clk);
        drive(1'b1, 5, 3, 1, 1, 6, 1, 1'b0, 1'b0, 1'b0);
        #1 chk_out("t3_rt_e", (FWD != 0) ? 0 : 1, 0, (FWD != 0) ? 2 : 0);
        idle(2);

        // $0 written and read in every stage never stalls or forwards
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b1, 0, 0, 0, 0, 0, 2, 1'b0, 1'b0, 1'b0);
            #1 chk_out($sformatf("t4_zero%0d", i), 0, 0, 0);
        end
        idle(2);

        // MDU: div -> 1 + 10 stall cycles, mult -> 1 + 5
        run_md("t5_div",  1'b1, 11, 10);
        run_md("t5_mult", 1'b0, 6, 5);

        // Reset while a div is busy clears everything at that edge
        @(negedge clk);
        drive(1'b1, 0, 0, 3, 3, 0, 0, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b1, 0, 0, 3, 3, 8, 1, 1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        #1 check("t6_busy_before", int'(hif.md_busy), 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk_out("t6_after_reset", 0, 0, 0);
        check("t6_after_reset.md_busy", int'(hif.md_busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
